// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the FIFO slice.
//   clog2     - constant ceil(log2(value)), usable in parameter expressions
//   MAX_DEPTH - largest supported FIFO depth
package fifo_pkg;

    localparam int MAX_DEPTH = 1024;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fwft_fifo_sync_ram.sv
// sync_ram_dual_port: simple dual-port RAM with a registered read.
// Port A writes, port B reads. A same-edge read of the address being
// written returns the old contents; the FIFO's bypass register covers that.
//   clk       - clock
//   we_a      - write enable, port A
//   addr_a    - write address
//   wdata_a   - write data
//   addr_b    - read address
//   rdata_b   - read data, valid the cycle after addr_b is presented
module sync_ram_dual_port #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [AW-1:0]    addr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/fwft_fifo.sv
// fwft_fifo: first-word-fall-through FIFO for profiling-counter samples.
// DEPTH may be any value 2..MAX_DEPTH. front shows the oldest word with no
// read-request cycle; push while full is accepted if a pop commits too.
//   clk, rst_n            - clock, synchronous active-low reset
//   flush                 - empty the FIFO at the next edge (errors kept)
//   enqueue, back         - push request and data
//   dequeue               - pop request
//   front, frontValid     - head word and its valid (= !empty)
//   full, empty           - level == DEPTH / level == 0
//   almostFull/Empty      - level >= AFULL_THRESH / level <= AEMPTY_THRESH
//   level                 - occupancy
//   overflow, underflow   - sticky error flags, cleared by clearErrors
module fwft_fifo import fifo_pkg::*; #(
    parameter int DEPTH         = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int LW           = clog2(DEPTH + 1),
    localparam int PW           = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  enqueue,
    input  logic [DATA_WIDTH-1:0] back,
    input  logic                  dequeue,
    output logic [DATA_WIDTH-1:0] front,
    output logic                  frontValid,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clearErrors
);

    logic [PW-1:0]         rd_ptr, rd_ptr_nxt;
    logic [PW-1:0]         wr_ptr;
    logic [LW-1:0]         level_q;
    logic                  commit_deq, commit_enq;
    logic                  do_deq, do_enq;
    logic                  overflow_set, underflow_set;
    logic                  byp_sel_q;
    logic [DATA_WIDTH-1:0] byp_q;
    logic [DATA_WIDTH-1:0] ram_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign frontValid = !empty;
    assign level      = level_q;
    assign almostFull  = (level_q >= LW'(AFULL_THRESH));
    assign almostEmpty = (level_q <= LW'(AEMPTY_THRESH));

    assign commit_deq = dequeue && !empty;
    assign commit_enq = enqueue && (!full || commit_deq);
    // Flush swallows both requests in its cycle.
    assign do_deq = commit_deq && !flush;
    assign do_enq = commit_enq && !flush;

    assign overflow_set  = enqueue && full && !commit_deq && !flush;
    assign underflow_set = dequeue && empty && !flush;

    // The RAM is addressed with the next head pointer so its registered
    // output already holds the new head right after a pop.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        if (!rst_n || flush) begin
            rd_ptr_nxt = '0;
        end else if (do_deq) begin
            rd_ptr_nxt = ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            byp_sel_q <= 1'b0;
        end else begin
            overflow  <= overflow_set  || (overflow  && !clearErrors);
            underflow <= underflow_set || (underflow && !clearErrors);
            if (flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                level_q   <= '0;
                byp_sel_q <= 1'b0;
            end else begin
                rd_ptr <= rd_ptr_nxt;
                if (do_enq) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (do_enq && !do_deq) begin
                    level_q <= level_q + LW'(1);
                end else if (do_deq && !do_enq) begin
                    level_q <= level_q - LW'(1);
                end
                // The RAM read returns stale data when the new head is the
                // word written this very edge (also the empty-to-one case).
                byp_sel_q <= do_enq && (wr_ptr == rd_ptr_nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            byp_q <= back;
        end
    end

    sync_ram_dual_port #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .we_a    (do_enq),
        .addr_a  (wr_ptr),
        .wdata_a (back),
        .addr_b  (rd_ptr_nxt),
        .rdata_b (ram_rdata)
    );

    assign front = byp_sel_q ? byp_q : ram_rdata;

endmodule

// File: tb/tb_fwft_fifo.sv
module tb_fwft_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;

    // DEPTH=16 instance
    logic        a_flush, a_enq, a_deq, a_clr;
    logic [31:0] a_back, a_front;
    logic        a_fv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0]  a_level;

    // DEPTH=5 instance
    logic        b_flush, b_enq, b_deq, b_clr;
    logic [31:0] b_back, b_front;
    logic        b_fv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_level;

    always #5 clk = ~clk;

    fwft_fifo #(.DEPTH(16), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .enqueue(a_enq), .back(a_back),
        .dequeue(a_deq), .front(a_front), .frontValid(a_fv), .full(a_full),
        .empty(a_empty), .almostFull(a_af), .almostEmpty(a_ae), .level(a_level),
        .overflow(a_ovf), .underflow(a_unf), .clearErrors(a_clr)
    );

    fwft_fifo #(.DEPTH(5), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .enqueue(b_enq), .back(b_back),
        .dequeue(b_deq), .front(b_front), .frontValid(b_fv), .full(b_full),
        .empty(b_empty), .almostFull(b_af), .almostEmpty(b_ae), .level(b_level),
        .overflow(b_ovf), .underflow(b_unf), .clearErrors(b_clr)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {a_flush, a_enq, a_deq, a_clr} = '0;
        {b_flush, b_enq, b_deq, b_clr} = '0;
        a_back = '0;
        b_back = '0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // reset state
        chk("rst_level", 32'(a_level), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_fv", 32'(a_fv), 0);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_ae", 32'(a_ae), 1);
        chk("rst_af", 32'(a_af), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_unf", 32'(a_unf), 0);
        chk("rst_b_empty", 32'(b_empty), 1);

        // fill DEPTH=16 with 0x11..0x20
        for (int i = 0; i < 16; i++) begin
            a_enq = 1'b1;
            a_back = 32'h11 + 32'(i);
            cycle();
            chk($sformatf("fill_level_%0d", i), 32'(a_level), 32'(i + 1));
            chk($sformatf("fill_front_%0d", i), a_front, 32'h11);
            chk($sformatf("fill_fv_%0d", i), 32'(a_fv), 1);
            chk($sformatf("fill_af_%0d", i), 32'(a_af), 32'((i + 1) >= 14));
            chk($sformatf("fill_ae_%0d", i), 32'(a_ae), 32'((i + 1) <= 2));
            chk($sformatf("fill_full_%0d", i), 32'(a_full), 32'((i + 1) == 16));
        end

        // full with push+pop for 4 cycles
        a_deq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_back = 32'h21 + 32'(k);
            cycle();
            chk($sformatf("pp_level_%0d", k), 32'(a_level), 16);
            chk($sformatf("pp_front_%0d", k), a_front, 32'h12 + 32'(k));
            chk($sformatf("pp_ovf_%0d", k), 32'(a_ovf), 0);
        end
        a_deq = 1'b0;

        // push with no pop while full: dropped
        a_back = 32'hEE;
        cycle();
        a_enq = 1'b0;
        chk("ovf_set", 32'(a_ovf), 1);
        chk("ovf_level", 32'(a_level), 16);

        // drain, order 0x15..0x24, 0xEE must never show
        a_deq = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_front_%0d", i), a_front, 32'h15 + 32'(i));
            cycle();
        end
        a_deq = 1'b0;
        chk("drain_empty", 32'(a_empty), 1);
        chk("drain_unf", 32'(a_unf), 0);

        a_clr = 1'b1;
        cycle();
        a_clr = 1'b0;
        chk("clr_ovf", 32'(a_ovf), 0);

        // underflow
        a_deq = 1'b1;
        cycle();
        chk("unf_set", 32'(a_unf), 1);
        chk("unf_level", 32'(a_level), 0);
        a_clr = 1'b1;
        cycle();
        chk("unf_set_wins", 32'(a_unf), 1);
        a_deq = 1'b0;
        cycle();
        a_clr = 1'b0;
        chk("unf_cleared", 32'(a_unf), 0);

        // flush at level 7 with an error flag held
        a_deq = 1'b1;
        cycle();
        a_deq = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_enq = 1'b1;
            a_back = 32'h31 + 32'(i);
            cycle();
        end
        chk("pre_flush_level", 32'(a_level), 7);
        chk("pre_flush_front", a_front, 32'h31);
        a_flush = 1'b1;
        a_back = 32'h99;
        cycle();
        a_flush = 1'b0;
        a_enq = 1'b0;
        chk("flush_level", 32'(a_level), 0);
        chk("flush_empty", 32'(a_empty), 1);
        chk("flush_unf", 32'(a_unf), 1);
        chk("flush_ovf", 32'(a_ovf), 0);
        a_enq = 1'b1;
        a_back = 32'h40;
        cycle();
        a_enq = 1'b0;
        chk("post_flush_front", a_front, 32'h40);
        chk("post_flush_level", 32'(a_level), 1);
        a_deq = 1'b1;
        a_clr = 1'b1;
        cycle();
        a_deq = 1'b0;
        a_clr = 1'b0;
        chk("post_flush_drain", 32'(a_empty), 1);

        // alternating push / pop at the empty boundary (20 cycles)
        for (int i = 0; i < 10; i++) begin
            a_enq = 1'b1;
            a_back = 32'h50 + 32'(i);
            cycle();
            a_enq = 1'b0;
            chk($sformatf("alt_front_%0d", i), a_front, 32'h50 + 32'(i));
            chk($sformatf("alt_fv_%0d", i), 32'(a_fv), 1);
            chk($sformatf("alt_lvl1_%0d", i), 32'(a_level), 1);
            a_deq = 1'b1;
            cycle();
            a_deq = 1'b0;
            chk($sformatf("alt_lvl0_%0d", i), 32'(a_level), 0);
        end

        // push+pop at level 1: new word must replace head next cycle
        a_enq = 1'b1;
        a_back = 32'h60;
        cycle();
        a_deq = 1'b1;
        a_back = 32'h61;
        cycle();
        a_enq = 1'b0;
        a_deq = 1'b0;
        chk("l1_pp_front", a_front, 32'h61);
        chk("l1_pp_level", 32'(a_level), 1);

        // DEPTH=5: misalign pointers, then 3 rounds of 5 pushes / 5 pops
        b_enq = 1'b1;
        b_back = 32'hA0;
        cycle();
        b_enq = 1'b0;
        b_deq = 1'b1;
        cycle();
        b_deq = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                b_enq = 1'b1;
                b_back = 32'h100 * 32'(r + 1) + 32'(i);
                cycle();
            end
            b_enq = 1'b0;
            chk($sformatf("b_full_%0d", r), 32'(b_full), 1);
            chk($sformatf("b_level_%0d", r), 32'(b_level), 5);
            b_deq = 1'b1;
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("b_front_%0d_%0d", r, i), b_front, 32'h100 * 32'(r + 1) + 32'(i));
                cycle();
            end
            b_deq = 1'b0;
            chk($sformatf("b_empty_%0d", r), 32'(b_empty), 1);
        end
        chk("b_ovf", 32'(b_ovf), 0);
        chk("b_unf", 32'(b_unf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
